// File: rtl/subtree_rr_arbiter.sv
// Round-robin arbiter sharing one downstream resource among the leaf instances of a sub-tree.
// Grants are held until done, request drop, or a bounded hold time, followed by one dead cycle.
module subtree_rr_arbiter #(
    parameter int N_REQ    = 5,
    parameter int MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         done,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     busy,
    output logic                     timeout
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   ptr, ptr_nxt;
    logic [CNT_W-1:0]  hold_cnt, hold_nxt;
    logic [N_REQ-1:0]  gnt_nxt;
    logic [ID_W-1:0]   id_nxt;
    logic              busy_nxt;
    logic              timeout_nxt;
    logic              pick_valid;
    logic [ID_W-1:0]   pick_id;
    logic              release_grant;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int offset);
        int sum;
        sum = (int'(base) + offset) % N_REQ;
        return ID_W'(sum);
    endfunction

    // Walk from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[wrap_idx(ptr, i)]) begin
                pick_valid = 1'b1;
                pick_id    = wrap_idx(ptr, i);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        hold_nxt      = hold_cnt;
        gnt_nxt       = gnt;
        id_nxt        = gnt_id;
        busy_nxt      = busy;
        timeout_nxt   = 1'b0;
        release_grant = done[gnt_id] || !req[gnt_id];

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = GRANT;
                    gnt_nxt   = ONE_HOT0 << pick_id;
                    id_nxt    = pick_id;
                    busy_nxt  = 1'b1;
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                // A voluntary release on the last allowed cycle is not a timeout.
                if (release_grant || hold_cnt == HOLD_LAST) begin
                    state_nxt   = GAP;
                    gnt_nxt     = '0;
                    id_nxt      = '0;
                    busy_nxt    = 1'b0;
                    hold_nxt    = '0;
                    ptr_nxt     = (gnt_id == ID_LAST) ? '0 : gnt_id + ID_W'(1);
                    timeout_nxt = !release_grant;
                end else begin
                    hold_nxt = hold_cnt + CNT_W'(1);
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            gnt      <= gnt_nxt;
            gnt_id   <= id_nxt;
            busy     <= busy_nxt;
            timeout  <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_subtree_rr_arbiter.sv
// Self-checking bench for subtree_rr_arbiter: per-scenario tasks plus a grant scoreboard
// that pairs every new grant with the owner index expected when its stimulus was driven.
module tb_subtree_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [4:0] req;
    logic [4:0] done;
    logic [4:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       timeout;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    logic busy_q = 1'b0;
    logic [9:0] obs_v, exp_v;

    subtree_rr_arbiter #(.N_REQ(5), .MAX_HOLD(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: each rising busy must match the oldest pending expected owner.
    always @(negedge clk) begin
        if (busy && !busy_q) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_grant got gnt=%b id=%0d expected no grant", gnt, gnt_id);
            end else begin
                int e;
                logic [4:0] eg;
                e  = exp_q.pop_front();
                eg = 5'b00001 << e;
                if (gnt_id !== 3'(e) || gnt !== eg) begin
                    failures++;
                    $display("FAIL sb_grant got gnt=%b id=%0d expected gnt=%b id=%0d", gnt, gnt_id, eg, e);
                end
            end
        end
        busy_q = busy;
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req   = '0;
        done  = '0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req   = 5'b11111;
        done  = '0;
        rst_n = 1'b0;
        step(2);
        obs_v = {gnt, gnt_id, busy, timeout};
        exp_v = {5'b00000, 3'd0, 1'b0, 1'b0};
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL reset_outputs got %h expected %h", obs_v, exp_v);
        end
        rst_n = 1'b1;
        exp_q.push_back(0);
        step();
        obs_v = {gnt, gnt_id, busy, timeout};
        exp_v = {5'b00001, 3'd0, 1'b1, 1'b0};
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL reset_first_grant got %h expected %h", obs_v, exp_v);
        end
        req = '0;
        step(3);
    endtask

    task automatic test_single();
        apply_reset();
        req = 5'b00100;
        exp_q.push_back(2);
        for (int c = 1; c <= 3; c++) begin
            step();
            if (c == 3) done = 5'b00100;
            obs_v = {gnt, gnt_id, busy, timeout};
            exp_v = {5'b00100, 3'd2, 1'b1, 1'b0};
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL single_hold c%0d got %h expected %h", c, obs_v, exp_v);
            end
        end
        exp_q.push_back(2);
        step();
        done  = '0;
        obs_v = {gnt, gnt_id, busy, timeout};
        exp_v = {5'b00000, 3'd0, 1'b0, 1'b0};
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL single_release got %h expected %h", obs_v, exp_v);
        end
        step();
        checks++;
        if (gnt !== 5'b00000) begin
            failures++;
            $display("FAIL single_gap got gnt=%b expected 00000", gnt);
        end
        step();
        checks++;
        if (gnt !== 5'b00100 || gnt_id !== 3'd2) begin
            failures++;
            $display("FAIL single_regrant got gnt=%b id=%0d expected 00100 id=2", gnt, gnt_id);
        end
        req = '0;
        step(3);
    endtask

    task automatic test_rotation();
        apply_reset();
        req = 5'b11111;
        for (int k = 0; k < 7; k++) begin
            int e;
            e = k % 5;
            exp_q.push_back(e);
            step();
            checks++;
            if (gnt_id !== 3'(e) || gnt !== (5'b00001 << e)) begin
                failures++;
                $display("FAIL rotation_grant k%0d got gnt=%b id=%0d expected id=%0d", k, gnt, gnt_id, e);
            end
            done = 5'b00001 << e;
            step();
            done = '0;
            checks++;
            if (gnt !== 5'b00000 || busy !== 1'b0 || timeout !== 1'b0) begin
                failures++;
                $display("FAIL rotation_release k%0d got gnt=%b busy=%b timeout=%b expected 00000 0 0",
                         k, gnt, busy, timeout);
            end
            step();
            checks++;
            if (gnt !== 5'b00000) begin
                failures++;
                $display("FAIL rotation_gap k%0d got gnt=%b expected 00000", k, gnt);
            end
        end
        req = '0;
        step(3);
    endtask

    task automatic test_timeout(input bit late_done);
        apply_reset();
        req = 5'b01000;
        exp_q.push_back(3);
        step();
        for (int c = 1; c <= 16; c++) begin
            if (late_done && c == 16) done = 5'b01000;
            obs_v = {gnt, gnt_id, busy, timeout};
            exp_v = {5'b01000, 3'd3, 1'b1, 1'b0};
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL timeout_hold late=%0d c%0d got %h expected %h", late_done, c, obs_v, exp_v);
            end
            step();
        end
        done  = '0;
        req   = '0;
        obs_v = {gnt, gnt_id, busy, timeout};
        exp_v = {5'b00000, 3'd0, 1'b0, !late_done};
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL timeout_revoke late=%0d got %h expected %h", late_done, obs_v, exp_v);
        end
        step();
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse_width late=%0d got %b expected 0", late_done, timeout);
        end
        step(2);
    endtask

    task automatic test_drop_ignored_done();
        apply_reset();
        req = 5'b00010;
        exp_q.push_back(1);
        step();
        done = 5'b10000;
        step();
        done  = '0;
        obs_v = {gnt, gnt_id, busy, timeout};
        exp_v = {5'b00010, 3'd1, 1'b1, 1'b0};
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL ignored_done got %h expected %h", obs_v, exp_v);
        end
        req = 5'b00000;
        step();
        checks++;
        if (gnt !== 5'b00000 || busy !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL drop_release got gnt=%b busy=%b timeout=%b expected 00000 0 0", gnt, busy, timeout);
        end
        req = 5'b00111;
        exp_q.push_back(2);
        step(2);
        checks++;
        if (gnt !== 5'b00100 || gnt_id !== 3'd2) begin
            failures++;
            $display("FAIL drop_ptr_advance got gnt=%b id=%0d expected 00100 id=2", gnt, gnt_id);
        end
        req = '0;
        step(3);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req = 5'b01000;
        exp_q.push_back(3);
        step(8);
        checks++;
        if (gnt !== 5'b01000) begin
            failures++;
            $display("FAIL midreset_pre got gnt=%b expected 01000", gnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        obs_v = {gnt, gnt_id, busy, timeout};
        exp_v = {5'b00000, 3'd0, 1'b0, 1'b0};
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL midreset_async_clear got %h expected %h", obs_v, exp_v);
        end
        req = 5'b11000;
        step();
        rst_n = 1'b1;
        exp_q.push_back(3);
        step();
        checks++;
        if (gnt !== 5'b01000 || gnt_id !== 3'd3) begin
            failures++;
            $display("FAIL midreset_regrant got gnt=%b id=%0d expected 01000 id=3", gnt, gnt_id);
        end
        req = '0;
        step(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t expected completion earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        test_reset();
        test_single();
        test_rotation();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_drop_ignored_done();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_pending got %0d grants outstanding expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
